acc_seq_ctrl: RTL and testbench
===============================

Name: acc_seq_ctrl

Overview:
- Sequencer for the 8-bit accumulate datapath: register plus adder feeding back into the register.
- Accepts a start command with an operand count, then takes exactly that many operands over a valid/ready handshake and sums them into an internal accumulator.
- Publishes the final sum with a carry flag and a one-cycle done pulse.
- Sits between an operand source (bus or testbench driver) and any consumer of the sum; it owns the accumulator's clear and enable.

Parameters:
- WIDTH, 8, operand/accumulator/result width in bits.
- CNT_W, 4, width of the operand-count field; max run length 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- len  input  CNT_W  operand count for the run; sampled with start.
- abort  input  1  cancel a run in progress; acts only in RUN.
- in_valid  input  1  operand present on in_data.
- in_data  input  WIDTH  operand.
- in_ready  output  1  block accepts an operand this cycle.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse, result valid.
- result  output  WIDTH  sum of the last completed run.
- carry  output  1  sticky unsigned overflow of the last completed run.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; acc=0; remaining=0; result=0; carry=0; done=0; busy=0; in_ready=0.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=0.
  - start=1 and len!=0 -> RUN next cycle; acc<=0; carry_acc<=0; remaining<=len.
  - start=1 and len==0 -> DONE next cycle; acc<=0; carry_acc<=0.
- RUN:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready at a rising edge. On a beat:
    - acc <= (acc+in_data) mod 2^WIDTH.
    - carry_acc |= carry-out of that add.
    - remaining <= remaining-1.
    - If remaining==1, go to DONE.
  - in_valid=0: hold all state; gaps of any length are legal.
  - abort=1 (with or without in_valid): go to IDLE; the beat in that cycle is not accepted; result and carry keep the previous run's values; no done pulse.
- DONE:
  - Lasts one cycle; done=1; in_ready=0.
  - result<=acc and carry<=carry_acc at the DONE->IDLE edge.
  - Always returns to IDLE.
  - result and carry hold until the next completed run.
- Latency: final beat accepted at edge t -> done=1 in cycle t..t+1; result/carry updated at edge t+1.
- start while busy is ignored; no queuing. A new start is accepted in the IDLE cycle right after DONE (back-to-back runs, 1 idle cycle minimum).
- in_data is ignored whenever in_ready=0.
- Arithmetic is unsigned with wrap-around modulo 2^WIDTH. carry records any intermediate carry-out, even if later beats would not reach past the wrap.
- Reset asserted mid-run: immediate return to the reset state; the partial sum is discarded.
- All outputs are registered or decoded from state only; no combinational path from in_valid to in_ready.

Test Plan:
- Reset check: drive reset=0 during random activity -> all outputs 0 and state IDLE asynchronously, before the next clk edge.
- Basic sum: start, len=3, beats 10,20,30 with in_valid held high -> 3 handshakes, done one cycle after the 3rd beat, result=60, carry=0.
- Overflow: len=2, beats 200,100 -> result=44, carry=1. Then a new run len=1, beat 5 -> result=5, carry=0.
- Backpressure and ignored inputs:
  - len=4, beats 1,2,3,4 with in_valid low for 2 cycles between each -> exactly 4 accepts, result=10.
  - start pulsed mid-run -> ignored, len unchanged.
  - in_data toggled while in_valid=0 -> no effect.
- Edge counts:
  - len=0 -> done the cycle after start, result=0, carry=0, in_ready never high.
  - len=15 with all beats 17 -> result=255, carry=0.
- Abort and mid-run reset:
  - After a run ending with result=60, start len=3, 1 beat, then abort -> IDLE, no done, result still 60.
  - Repeat, but assert reset instead of abort -> result=0.

Source files
------------

// File: rtl/acc_seq_ctrl.sv
// Accumulate sequencer: takes a counted run of operands over valid/ready,
// sums them into an 8-bit accumulator and publishes result, sticky carry and a done pulse.
module acc_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic             carry_acc;
    logic [CNT_W-1:0] remaining;
    logic             beat;
    logic [WIDTH:0]   sum;

    // Handshake outputs decode state only, so in_ready never depends on in_valid.
    assign in_ready = (state == S_RUN);
    assign busy     = (state == S_RUN) || (state == S_DONE);
    assign done     = (state == S_DONE);

    // Abort wins over a coincident beat.
    assign beat = in_ready && in_valid && !abort;
    assign sum  = {1'b0, acc} + {1'b0, in_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (len != '0) ? S_RUN : S_DONE;
            S_RUN: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (beat && remaining == CNT_W'(1))
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            carry_acc <= 1'b0;
            remaining <= '0;
            result    <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        carry_acc <= 1'b0;
                        remaining <= len;
                    end
                end
                S_RUN: begin
                    if (beat) begin
                        acc       <= sum[WIDTH-1:0];
                        carry_acc <= carry_acc | sum[WIDTH];
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Published values only change on a completed run.
                    result <= acc;
                    carry  <= carry_acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: directed scenarios plus randomized runs, checked against
// an integer-sum model (result = total mod 256, carry = total > 255).
module tb_acc_seq_ctrl;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready, busy, done, carry;
    logic [WIDTH-1:0] result;

    acc_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .result(result), .carry(carry)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] ops[$];
    int r_accepts, r_done_cnt;
    bit r_done_ok, r_ready_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer sum of the operands of a run.
    function automatic void model(input int n, output logic [WIDTH-1:0] r, output bit c);
        int t = 0;
        for (int i = 0; i < n; i++) t += int'(ops[i]);
        r = t[WIDTH-1:0];
        c = (t > 255);
    endfunction

    // Drives one run from IDLE through the cycle after DONE and records what it saw.
    task automatic drive_run(input int n, input int gap_min, input int gap_max, input bit poke_start);
        int  idx = 0;
        int  gap = 0;
        int  budget = 0;
        bit  take;
        r_accepts = 0; r_done_cnt = 0; r_done_ok = 0; r_ready_seen = 0;
        if (in_ready) r_ready_seen = 1;
        start = 1'b1; len = n[CNT_W-1:0];
        tick();
        start = 1'b0; len = CNT_W'($urandom);
        if (done) begin r_done_cnt++; r_done_ok = (n == 0); end
        while (r_done_cnt == 0 && budget < 400) begin
            budget++;
            if (gap > 0) begin
                in_valid = 1'b0; in_data = WIDTH'($urandom); gap--;
            end else begin
                in_valid = (idx < ops.size());
                in_data  = (idx < ops.size()) ? ops[idx] : WIDTH'($urandom);
            end
            start = poke_start && ($urandom_range(3, 0) == 0);
            len   = CNT_W'($urandom);
            if (in_ready) r_ready_seen = 1;
            take = in_valid && in_ready;
            tick();
            if (take) begin idx++; r_accepts++; gap = $urandom_range(gap_max, gap_min); end
            if (done) begin r_done_cnt++; r_done_ok = take && (r_accepts == n); end
        end
        in_valid = 1'b0; start = 1'b0;
        tick();
        if (done) r_done_cnt++;
    endtask

    task automatic check_run(input string name, input int n);
        logic [WIDTH-1:0] er;
        bit ec;
        model(n, er, ec);
        n_vec++;
        if (result !== er) begin n_err++; $display("FAIL %s_result: got %0d want %0d", name, result, er); end
        n_vec++;
        if (carry !== ec) begin n_err++; $display("FAIL %s_carry: got %0b want %0b", name, carry, ec); end
        n_vec++;
        if (r_accepts !== n) begin n_err++; $display("FAIL %s_accepts: got %0d want %0d", name, r_accepts, n); end
        n_vec++;
        if (!r_done_ok || r_done_cnt !== 1) begin
            n_err++; $display("FAIL %s_done: timing_ok %0b pulses %0d want 1/1", name, r_done_ok, r_done_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_vec++;
        if ({in_ready, busy, done, result, carry} !== '0) begin
            n_err++; $display("FAIL reset_state: got %b want 0", {in_ready, busy, done, result, carry});
        end
        @(negedge clk); reset = 1'b1;
        tick();
        ops = {8'd100, 8'd50};
        drive_run(2, 0, 1, 0);
        check_run("pre_reset", 2);
        start = 1'b1; len = 4'd5; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 8'd33; tick(); tick();
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, busy, done, result, carry} !== '0) begin
            n_err++; $display("FAIL async_reset: got %b want 0", {in_ready, busy, done, result, carry});
        end
        in_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        ops = {8'd10, 8'd20, 8'd30};
        drive_run(3, 0, 0, 0);
        check_run("basic", 3);
    endtask

    task automatic test_overflow();
        ops = {8'd200, 8'd100};
        drive_run(2, 0, 0, 0);
        check_run("overflow", 2);
        ops = {8'd5};
        drive_run(1, 0, 0, 0);
        check_run("after_overflow", 1);
    endtask

    task automatic test_backpressure();
        ops = {8'd1, 8'd2, 8'd3, 8'd4};
        drive_run(4, 2, 2, 1);
        check_run("backpressure", 4);
    endtask

    task automatic test_edge_counts();
        ops.delete();
        drive_run(0, 0, 0, 0);
        check_run("len0", 0);
        n_vec++;
        if (r_ready_seen !== 1'b0) begin n_err++; $display("FAIL len0_ready: got %0b want 0", r_ready_seen); end
        ops.delete();
        for (int i = 0; i < 15; i++) ops.push_back(8'd17);
        drive_run(15, 0, 1, 0);
        check_run("len15", 15);
    endtask

    task automatic test_abort();
        int dcnt = 0;
        ops = {8'd10, 8'd20, 8'd30};
        drive_run(3, 0, 0, 0);
        check_run("abort_setup", 3);
        start = 1'b1; len = 4'd3; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 8'd7; tick();
        in_data = 8'd9; abort = 1'b1; tick();
        abort = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL abort_idle: busy %0b done %0b want 0 0", busy, done);
        end
        for (int i = 0; i < 3; i++) begin if (done) dcnt++; tick(); end
        n_vec++;
        if (dcnt !== 0 || result !== 8'd60 || carry !== 1'b0) begin
            n_err++; $display("FAIL abort_hold: done %0d result %0d carry %0b want 0 60 0", dcnt, result, carry);
        end
        ops = {8'd4};
        drive_run(1, 0, 0, 0);
        check_run("after_abort", 1);
        ops = {8'd10, 8'd20, 8'd30};
        drive_run(3, 0, 0, 0);
        start = 1'b1; len = 4'd3; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 8'd7; tick();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (result !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midrun_reset: result %0d busy %0b done %0b want 0 0 0", result, busy, done);
        end
        @(negedge clk); reset = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        ops = {8'd255, 8'd1};
        drive_run(2, 0, 0, 0);
        check_run("b2b_first", 2);
        ops = {8'd9, 8'd8, 8'd7};
        drive_run(3, 0, 0, 0);
        check_run("b2b_second", 3);
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(15, 0);
            ops.delete();
            for (int i = 0; i < n; i++) ops.push_back(WIDTH'($urandom));
            drive_run(n, 0, $urandom_range(3, 0), $urandom_range(1, 0) == 1);
            check_run("random", n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_edge_counts();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
